// File: rtl/issue_rat_freelist_checkpoint_ctrl_pkg.sv
// Shared defaults and FSM encoding for the free-list checkpoint controller.
package issue_rat_freelist_checkpoint_ctrl_pkg;

    localparam int PRF_WIDTH_DEF  = 6;
    localparam int FGR_WIDTH_DEF  = 3;
    localparam int NUM_BANKS_DEF  = 4;
    localparam int BANK_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        DRAIN = 2'd2
    } ckpt_state_e;

endpackage

// File: rtl/issue_rat_freelist_checkpoint_ctrl_match.sv
// Combinational FGR CAM over the live bank window [head, head+count).
// Returns the oldest hit and a mask of that bank plus every younger live bank.
module issue_rat_freelist_checkpoint_match
    import issue_rat_freelist_checkpoint_ctrl_pkg::*;
#(
    parameter int FGR_WIDTH = FGR_WIDTH_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int PTR_W     = $clog2(NUM_BANKS)
) (
    input  logic [NUM_BANKS-1:0][FGR_WIDTH-1:0] fgr,
    input  logic [NUM_BANKS-1:0]                tag_live,
    input  logic [FGR_WIDTH-1:0]                key,
    input  logic [PTR_W-1:0]                    head,
    input  logic [PTR_W:0]                      count,
    output logic                                hit,
    output logic [PTR_W-1:0]                    idx,
    output logic [NUM_BANKS-1:0]                age_mask
);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] hit_off;

    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        hit_off  = '0;
        age_mask = '0;
        // Walk by age offset so the pointer arithmetic wraps naturally.
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (!hit && CNT_W'(k) < count && tag_live[head + PTR_W'(k)] &&
                fgr[head + PTR_W'(k)] == key) begin
                hit     = 1'b1;
                idx     = head + PTR_W'(k);
                hit_off = CNT_W'(k);
            end
        end
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (hit && CNT_W'(k) >= hit_off && CNT_W'(k) < count)
                age_mask[head + PTR_W'(k)] = 1'b1;
        end
    end

endmodule

// File: rtl/issue_rat_freelist_checkpoint_ctrl.sv
// Checkpoint ring controller: allocates, releases and drains free-list banks.
// Optional sticky protocol checker: ISSUE_RAT_FREELIST_CHECKPOINT_CTRL_ERRCHK_EN.
module issue_rat_freelist_checkpoint_ctrl
    import issue_rat_freelist_checkpoint_ctrl_pkg::*;
#(
    parameter int PRF_WIDTH  = PRF_WIDTH_DEF,
    parameter int FGR_WIDTH  = FGR_WIDTH_DEF,
    parameter int NUM_BANKS  = NUM_BANKS_DEF,
    parameter int BANK_DEPTH = BANK_DEPTH_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cp_i_valid,
    input  logic [FGR_WIDTH-1:0]                cp_i_fgr,
    output logic                                cp_o_ready,
    input  logic                                alloc_i_valid,
    input  logic [PRF_WIDTH-1:0]                alloc_i_prf,
    output logic                                alloc_o_ready,
    input  logic                                rsv_i_valid,
    input  logic [FGR_WIDTH-1:0]                rsv_i_fgr,
    input  logic                                msp_i_valid,
    input  logic [FGR_WIDTH-1:0]                msp_i_fgr,
    output logic                                free_o_valid,
    output logic [PRF_WIDTH-1:0]                free_o_prf,
    output logic                                busy_o,
    output logic                                err_o,
    output logic [NUM_BANKS-1:0]                bank_o_tag_wen,
    output logic                                bank_o_tag_valid,
    output logic                                bank_o_tag_abandoned,
    input  logic [NUM_BANKS-1:0]                bank_i_tag_valid,
    input  logic [NUM_BANKS-1:0]                bank_i_tag_abandoned,
    output logic [NUM_BANKS-1:0]                bank_o_fgr_wen,
    output logic [FGR_WIDTH-1:0]                bank_o_fgr,
    input  logic [NUM_BANKS-1:0][FGR_WIDTH-1:0] bank_i_fgr,
    output logic [NUM_BANKS-1:0]                bank_o_fifo_reset,
    output logic [NUM_BANKS-1:0]                bank_o_fifo_wen,
    output logic [PRF_WIDTH-1:0]                bank_o_fifo_prf,
    output logic [NUM_BANKS-1:0]                bank_o_fifo_ren,
    input  logic [NUM_BANKS-1:0][PRF_WIDTH-1:0] bank_i_fifo_prf,
    input  logic [NUM_BANKS-1:0]                bank_i_fifo_full,
    input  logic [NUM_BANKS-1:0]                bank_i_fifo_empty
);
    localparam int              PTR_W    = $clog2(NUM_BANKS);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BANKS);

    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 || BANK_DEPTH < 1) begin : g_bad_cfg
        $error("NUM_BANKS must be a power of two >= 2 and BANK_DEPTH >= 1");
    end

    ckpt_state_e          state_q, state_d;
    logic [PTR_W-1:0]     head_q, tail_q, mark_q, tail_m1, msp_idx;
    logic [CNT_W-1:0]     count_q;
    logic [NUM_BANKS-1:0] live_tag, msp_mask;
    logic                 idle, msp_hit;
    logic                 cp_fire, alloc_fire, rsv_fire, msp_fire, drain_pop, drain_rel;

    assign tail_m1  = tail_q - 1'b1;
    assign live_tag = bank_i_tag_valid & ~bank_i_tag_abandoned;
    // Outputs are gated by reset so they read idle while reset is held low.
    assign idle     = reset && state_q == IDLE;

    assign cp_o_ready    = idle && count_q != FULL_CNT && !msp_i_valid;
    assign alloc_o_ready = idle && !msp_i_valid && (count_q == '0 || !bank_i_fifo_full[tail_m1]);
    assign cp_fire       = cp_i_valid && cp_o_ready;
    assign alloc_fire    = alloc_i_valid && alloc_o_ready;
    assign rsv_fire      = idle && !msp_i_valid && rsv_i_valid && count_q != '0 &&
                           bank_i_fgr[head_q] == rsv_i_fgr;
    assign msp_fire      = idle && msp_i_valid && msp_hit;
    assign drain_pop     = reset && state_q == DRAIN && !bank_i_fifo_empty[tail_m1];
    assign drain_rel     = reset && state_q == DRAIN && bank_i_fifo_empty[tail_m1];

    issue_rat_freelist_checkpoint_match #(
        .FGR_WIDTH(FGR_WIDTH), .NUM_BANKS(NUM_BANKS), .PTR_W(PTR_W)
    ) u_msp_match (
        .fgr(bank_i_fgr), .tag_live(live_tag), .key(msp_i_fgr), .head(head_q),
        .count(count_q), .hit(msp_hit), .idx(msp_idx), .age_mask(msp_mask)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (msp_fire) state_d = MARK;
            MARK:    state_d = DRAIN;
            DRAIN:   if (drain_rel && tail_m1 == mark_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bank_o_tag_wen       = '0;
        bank_o_tag_valid     = 1'b0;
        bank_o_tag_abandoned = 1'b0;
        bank_o_fgr_wen       = '0;
        bank_o_fgr           = '0;
        bank_o_fifo_reset    = '1;
        bank_o_fifo_wen      = '0;
        bank_o_fifo_prf      = '0;
        bank_o_fifo_ren      = '0;
        free_o_valid         = 1'b0;
        free_o_prf           = '0;
        busy_o               = reset && (state_q == MARK || state_q == DRAIN);
        unique case (state_q)
            IDLE: begin
                if (msp_fire) begin
                    bank_o_tag_wen       = msp_mask;
                    bank_o_tag_valid     = 1'b1;
                    bank_o_tag_abandoned = 1'b1;
                end else begin
                    // Tag data is shared: a same-cycle checkpoint owns it. The released
                    // bank sits outside the head/tail window, so its stale valid is harmless.
                    if (rsv_fire) begin
                        bank_o_fifo_reset[head_q] = 1'b0;
                        if (!cp_fire) bank_o_tag_wen[head_q] = 1'b1;
                    end
                    if (cp_fire) begin
                        bank_o_tag_wen[tail_q]    = 1'b1;
                        bank_o_tag_valid          = 1'b1;
                        bank_o_fgr_wen[tail_q]    = 1'b1;
                        bank_o_fgr                = cp_i_fgr;
                        bank_o_fifo_reset[tail_q] = 1'b0;
                    end
                    if (alloc_fire && count_q != '0) begin
                        bank_o_fifo_wen[tail_m1] = 1'b1;
                        bank_o_fifo_prf          = alloc_i_prf;
                    end
                end
            end
            DRAIN: begin
                if (drain_pop) begin
                    bank_o_fifo_ren[tail_m1] = 1'b1;
                    free_o_valid             = 1'b1;
                    free_o_prf               = bank_i_fifo_prf[tail_m1];
                end else if (drain_rel) begin
                    bank_o_tag_wen[tail_m1]    = 1'b1;
                    bank_o_fifo_reset[tail_m1] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mark_q  <= '0;
        end else begin
            if (msp_fire)  mark_q <= msp_idx;
            if (cp_fire)   tail_q <= tail_q + 1'b1;
            if (drain_rel) tail_q <= tail_m1;
            if (rsv_fire)  head_q <= head_q + 1'b1;
            count_q <= count_q + CNT_W'(cp_fire) - CNT_W'(rsv_fire) - CNT_W'(drain_rel);
        end
    end

`ifdef ISSUE_RAT_FREELIST_CHECKPOINT_CTRL_ERRCHK_EN
    logic                 err_q, dup_hit;
    logic [PTR_W-1:0]     dup_idx_unused;
    logic [NUM_BANKS-1:0] dup_mask_unused;

    issue_rat_freelist_checkpoint_match #(
        .FGR_WIDTH(FGR_WIDTH), .NUM_BANKS(NUM_BANKS), .PTR_W(PTR_W)
    ) u_dup_match (
        .fgr(bank_i_fgr), .tag_live(live_tag), .key(cp_i_fgr), .head(head_q),
        .count(count_q), .hit(dup_hit), .idx(dup_idx_unused), .age_mask(dup_mask_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else if ((idle && !msp_i_valid && rsv_i_valid &&
                  (count_q == '0 || bank_i_fgr[head_q] != rsv_i_fgr)) ||
                 (idle && msp_i_valid && !msp_hit) ||
                 (cp_fire && dup_hit))
            err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_issue_rat_freelist_checkpoint_ctrl.sv
// Directed + random bench: bank ring environment plus a checkpoint-list reference model.
module tb_issue_rat_freelist_checkpoint_ctrl;
    localparam int PW = 6, FW = 3, NB = 4, DP = 4;
`ifdef ISSUE_RAT_FREELIST_CHECKPOINT_CTRL_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0;
    logic cp_i_valid, alloc_i_valid, rsv_i_valid, msp_i_valid;
    logic [FW-1:0] cp_i_fgr, rsv_i_fgr, msp_i_fgr;
    logic [PW-1:0] alloc_i_prf;
    logic cp_o_ready, alloc_o_ready, free_o_valid, busy_o, err_o;
    logic [PW-1:0] free_o_prf;
    logic [NB-1:0] bank_o_tag_wen, bank_i_tag_valid, bank_i_tag_abandoned, bank_o_fgr_wen;
    logic bank_o_tag_valid, bank_o_tag_abandoned;
    logic [FW-1:0] bank_o_fgr;
    logic [NB-1:0][FW-1:0] bank_i_fgr;
    logic [NB-1:0] bank_o_fifo_reset, bank_o_fifo_wen, bank_o_fifo_ren, bank_i_fifo_full, bank_i_fifo_empty;
    logic [PW-1:0] bank_o_fifo_prf;
    logic [NB-1:0][PW-1:0] bank_i_fifo_prf;

    issue_rat_freelist_checkpoint_ctrl #(.PRF_WIDTH(PW), .FGR_WIDTH(FW), .NUM_BANKS(NB), .BANK_DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .cp_i_valid(cp_i_valid), .cp_i_fgr(cp_i_fgr), .cp_o_ready(cp_o_ready),
        .alloc_i_valid(alloc_i_valid), .alloc_i_prf(alloc_i_prf), .alloc_o_ready(alloc_o_ready),
        .rsv_i_valid(rsv_i_valid), .rsv_i_fgr(rsv_i_fgr), .msp_i_valid(msp_i_valid), .msp_i_fgr(msp_i_fgr),
        .free_o_valid(free_o_valid), .free_o_prf(free_o_prf), .busy_o(busy_o), .err_o(err_o),
        .bank_o_tag_wen(bank_o_tag_wen), .bank_o_tag_valid(bank_o_tag_valid),
        .bank_o_tag_abandoned(bank_o_tag_abandoned), .bank_i_tag_valid(bank_i_tag_valid),
        .bank_i_tag_abandoned(bank_i_tag_abandoned), .bank_o_fgr_wen(bank_o_fgr_wen),
        .bank_o_fgr(bank_o_fgr), .bank_i_fgr(bank_i_fgr), .bank_o_fifo_reset(bank_o_fifo_reset),
        .bank_o_fifo_wen(bank_o_fifo_wen), .bank_o_fifo_prf(bank_o_fifo_prf),
        .bank_o_fifo_ren(bank_o_fifo_ren), .bank_i_fifo_prf(bank_i_fifo_prf),
        .bank_i_fifo_full(bank_i_fifo_full), .bank_i_fifo_empty(bank_i_fifo_empty)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bank ring environment
    logic          e_tv[NB], e_ta[NB];
    logic [FW-1:0] e_fgr[NB];
    int            fq[NB][$];

    // Reference model: live checkpoints oldest-first, PRF records tagged by checkpoint id,
    // and a per-cycle script of (free_valid, prf) while a drain is in flight.
    int ck_fgr[$], ck_id[$], rec_id[$], rec_prf[$], scr_v[$], scr_p[$];
    int next_id;
    bit m_cp, m_al;

    // Outputs captured just before each rising edge
    logic c_cp_rdy, c_al_rdy, c_busy, c_fv, c_tag_v, c_tag_ab;
    logic [PW-1:0] c_fp, c_wprf;
    logic [FW-1:0] c_fgr;
    logic [NB-1:0] c_tag_wen, c_fgr_wen, c_frst, c_wen, c_ren;

    function automatic void env_drive();
        for (int b = 0; b < NB; b++) begin
            bank_i_tag_valid[b]     = e_tv[b];
            bank_i_tag_abandoned[b] = e_ta[b];
            bank_i_fgr[b]           = e_fgr[b];
            bank_i_fifo_full[b]     = fq[b].size() >= DP;
            bank_i_fifo_empty[b]    = fq[b].size() == 0;
            bank_i_fifo_prf[b]      = fq[b].size() > 0 ? PW'(fq[b][0]) : '0;
        end
    endfunction

    function automatic void clear_all();
        for (int b = 0; b < NB; b++) begin
            e_tv[b] = 1'b0; e_ta[b] = 1'b0; e_fgr[b] = '0; fq[b].delete();
        end
        ck_fgr.delete(); ck_id.delete(); rec_id.delete(); rec_prf.delete();
        scr_v.delete(); scr_p.delete(); next_id = 0;
        env_drive();
    endfunction

    function automatic void clear_inputs();
        cp_i_valid = 0; alloc_i_valid = 0; rsv_i_valid = 0; msp_i_valid = 0;
        cp_i_fgr = '0; rsv_i_fgr = '0; msp_i_fgr = '0; alloc_i_prf = '0;
    endfunction

    function automatic int young_cnt();
        int c = 0;
        foreach (rec_id[i]) if (rec_id[i] == ck_id[ck_id.size()-1]) c++;
        return c;
    endfunction

    function automatic void purge(input int id);
        int ti[$], tp[$];
        foreach (rec_id[i]) if (rec_id[i] != id) begin ti.push_back(rec_id[i]); tp.push_back(rec_prf[i]); end
        rec_id = ti; rec_prf = tp;
    endfunction

    task automatic model_check();
        int n = ck_fgr.size();
        bit busy = scr_v.size() > 0;
        m_cp = !busy && n < NB && !msp_i_valid;
        m_al = !busy && !msp_i_valid && (n == 0 || young_cnt() < DP);
        chk("cp_ready", c_cp_rdy, m_cp);
        chk("alloc_ready", c_al_rdy, m_al);
        chk("busy", c_busy, busy);
        chk("free_valid", c_fv, busy ? scr_v[0] : 0);
        if (busy && scr_v[0] == 1) chk("free_prf", c_fp, scr_p[0]);
    endtask

    function automatic void model_update();
        int n = ck_fgr.size();
        if (scr_v.size() > 0) begin
            void'(scr_v.pop_front()); void'(scr_p.pop_front());
        end else if (msp_i_valid) begin
            int p = -1;
            foreach (ck_fgr[i]) if (p < 0 && ck_fgr[i] == int'(msp_i_fgr)) p = i;
            if (p >= 0) begin
                scr_v.push_back(0); scr_p.push_back(0);
                for (int k = n - 1; k >= p; k--) begin
                    foreach (rec_id[i]) if (rec_id[i] == ck_id[k]) begin scr_v.push_back(1); scr_p.push_back(rec_prf[i]); end
                    scr_v.push_back(0); scr_p.push_back(0);
                    purge(ck_id[k]);
                end
                while (ck_fgr.size() > p) begin void'(ck_fgr.pop_back()); void'(ck_id.pop_back()); end
            end
        end else begin
            if (alloc_i_valid && m_al && n > 0) begin rec_id.push_back(ck_id[n-1]); rec_prf.push_back(int'(alloc_i_prf)); end
            if (rsv_i_valid && n > 0 && ck_fgr[0] == int'(rsv_i_fgr)) begin
                purge(ck_id[0]); void'(ck_fgr.pop_front()); void'(ck_id.pop_front());
            end
            if (cp_i_valid && m_cp) begin ck_fgr.push_back(int'(cp_i_fgr)); ck_id.push_back(next_id); next_id++; end
        end
    endfunction

    function automatic void env_update();
        for (int b = 0; b < NB; b++) begin
            if (c_tag_wen[b]) begin e_tv[b] = c_tag_v; e_ta[b] = c_tag_ab; end
            if (c_fgr_wen[b]) e_fgr[b] = c_fgr;
            if (!c_frst[b]) fq[b].delete();
            else begin
                if (c_ren[b] && fq[b].size() > 0) void'(fq[b].pop_front());
                if (c_wen[b]) fq[b].push_back(int'(c_wprf));
            end
        end
        env_drive();
    endfunction

    // Starts and ends at a falling edge.
    task automatic tick();
        #4;
        c_cp_rdy = cp_o_ready; c_al_rdy = alloc_o_ready; c_busy = busy_o; c_fv = free_o_valid; c_fp = free_o_prf;
        c_tag_wen = bank_o_tag_wen; c_tag_v = bank_o_tag_valid; c_tag_ab = bank_o_tag_abandoned;
        c_fgr_wen = bank_o_fgr_wen; c_fgr = bank_o_fgr; c_frst = bank_o_fifo_reset;
        c_wen = bank_o_fifo_wen; c_wprf = bank_o_fifo_prf; c_ren = bank_o_fifo_ren;
        model_check();
        @(posedge clk); #1;
        model_update();
        env_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; clear_inputs(); clear_all();
        @(negedge clk); #1;
        chk("rst_fifo_reset", bank_o_fifo_reset, 4'hF);
        chk("rst_cp_ready", cp_o_ready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cp(input int f);
        cp_i_valid = 1; cp_i_fgr = FW'(f); tick(); cp_i_valid = 0;
    endtask

    task automatic alloc(input int p);
        alloc_i_valid = 1; alloc_i_prf = PW'(p); tick(); alloc_i_valid = 0;
    endtask

    initial begin
        int freed[$];
        int nbusy;
        clear_inputs(); clear_all();
        do_reset();

        // checkpoint into bank0
        cp(3);
        chk("t1_tag_wen", c_tag_wen, 4'b0001);
        chk("t1_tag_valid", c_tag_v, 1);
        chk("t1_fgr_wen", c_fgr_wen, 4'b0001);
        chk("t1_fgr", c_fgr, 3);
        chk("t1_fifo_reset", c_frst, 4'b1110);
        chk("t1_bank0_fgr", e_fgr[0], 3);
        // fill bank0
        for (int i = 0; i < 5; i++) alloc(10 + i);
        chk("t2_full_ready", c_al_rdy, 0);
        chk("t2_depth", fq[0].size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_order", fq[0][i], 10 + i);

        // ring full, resolve head, reuse bank0
        do_reset();
        for (int i = 1; i <= 4; i++) cp(i);
        cp(5);
        chk("t3_ring_full", c_cp_rdy, 0);
        rsv_i_valid = 1; rsv_i_fgr = 3'd1; tick(); rsv_i_valid = 0;
        chk("t3_bank0_released", e_tv[0], 0);
        cp(5);
        chk("t3_reuse_ready", c_cp_rdy, 1);
        chk("t3_bank0_fgr", e_fgr[0], 5);

        // mispredict drain: youngest first, FIFO order
        do_reset();
        cp(1); alloc(5); alloc(6); cp(2); alloc(7);
        msp_i_valid = 1; msp_i_fgr = 3'd1; tick(); msp_i_valid = 0;
        nbusy = 0; freed.delete();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c_fv) freed.push_back(int'(c_fp));
            if (c_busy) nbusy++; else break;
        end
        chk("t4_drain_done", c_busy, 0);
        chk("t4_busy_cycles", nbusy, 6);
        chk("t4_free_count", freed.size(), 3);
        if (freed.size() == 3) begin
            chk("t4_free0", freed[0], 7); chk("t4_free1", freed[1], 5); chk("t4_free2", freed[2], 6);
        end
        chk("t4_bank0_inv", e_tv[0], 0);
        chk("t4_bank1_inv", e_tv[1], 0);

        // mispredict drops alloc; non-head resolve ignored
        do_reset();
        cp(1); alloc(20);
        chk("t5_err_clean", err_o, 0);
        msp_i_valid = 1; msp_i_fgr = 3'd6; alloc_i_valid = 1; alloc_i_prf = 6'd21; tick();
        msp_i_valid = 0; alloc_i_valid = 0;
        chk("t5_alloc_dropped", c_al_rdy, 0);
        chk("t5_fifo_size", fq[0].size(), 1);
        rsv_i_valid = 1; rsv_i_fgr = 3'd2; tick(); rsv_i_valid = 0;
        chk("t5_rsv_ignored", e_tv[0], 1);
        chk("t5_err", err_o, ERR_EXP);

        // reset during drain
        do_reset();
        cp(1); alloc(30); alloc(31); cp(2); alloc(32);
        msp_i_valid = 1; msp_i_fgr = 3'd1; tick(); msp_i_valid = 0;
        tick(); tick();
        reset = 1'b0; #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_free_valid", free_o_valid, 0);
        chk("t6_fifo_reset", bank_o_fifo_reset, 4'hF);
        chk("t6_ren", bank_o_fifo_ren, 0);
        chk("t6_cp_ready", cp_o_ready, 0);
        clear_all();
        @(negedge clk); reset = 1'b1;
        alloc(40);
        chk("t6_count0_alloc", c_al_rdy, 1);
        chk("t6_no_push", fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size(), 0);

        // randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int n = ck_fgr.size();
            int f;
            cp_i_valid = ($urandom % 3) == 0;
            do begin
                f = int'($urandom % 8);
            end while (f inside {ck_fgr});
            cp_i_fgr = FW'(f);
            alloc_i_valid = ($urandom % 2) == 0;
            alloc_i_prf = PW'($urandom);
            rsv_i_valid = ($urandom % 5) == 0;
            rsv_i_fgr = (n > 0 && ($urandom % 4) != 0) ? FW'(ck_fgr[0]) : FW'($urandom);
            msp_i_valid = ($urandom % 12) == 0;
            msp_i_fgr = (n > 0 && ($urandom % 5) != 0) ? FW'(ck_fgr[$urandom % n]) : FW'($urandom);
            tick();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_rat_freelist_checkpoint_ctrl.md
Name: issue_rat_freelist_checkpoint_ctrl

Overview:
- Controller directly upstream of a ring of NUM_BANKS free-list checkpoint banks; owns all their tag, FGR and FIFO control ports.
- Allocates a bank per branch checkpoint and records every PRF popped from the free list into the youngest live bank.
- Releases the oldest bank when its branch resolves correct.
- On mispredict, abandons the bank and all younger banks, then drains their PRFs back to the free list one per cycle.

Parameters:
PRF_WIDTH, 6, physical register index width
FGR_WIDTH, 3, checkpoint (FGR) tag width
NUM_BANKS, 4, checkpoint bank count; power of two, at least 2
BANK_DEPTH, 4, entries per bank FIFO

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cp_i_valid  in  1  new checkpoint request
cp_i_fgr  in  FGR_WIDTH  FGR of new checkpoint
cp_o_ready  out  1  checkpoint accepted when valid&ready
alloc_i_valid  in  1  PRF popped from free list this cycle
alloc_i_prf  in  PRF_WIDTH  popped PRF
alloc_o_ready  out  1  record accepted
rsv_i_valid  in  1  branch resolved correct
rsv_i_fgr  in  FGR_WIDTH  resolved FGR
msp_i_valid  in  1  branch mispredicted
msp_i_fgr  in  FGR_WIDTH  mispredicted FGR
free_o_valid  out  1  PRF returned to free list
free_o_prf  out  PRF_WIDTH  returned PRF
busy_o  out  1  drain in progress
err_o  out  1  protocol error (optional feature)
bank_o_tag_wen  out  NUM_BANKS  per-bank tag write enable
bank_o_tag_valid  out  1  shared tag valid data
bank_o_tag_abandoned  out  1  shared tag abandoned data
bank_i_tag_valid  in  NUM_BANKS  per-bank valid
bank_i_tag_abandoned  in  NUM_BANKS  per-bank abandoned
bank_o_fgr_wen  out  NUM_BANKS  per-bank FGR write enable
bank_o_fgr  out  FGR_WIDTH  shared FGR data
bank_i_fgr  in  NUM_BANKS*FGR_WIDTH  per-bank FGR
bank_o_fifo_reset  out  NUM_BANKS  per-bank FIFO clear, active-low
bank_o_fifo_wen  out  NUM_BANKS  per-bank push
bank_o_fifo_prf  out  PRF_WIDTH  shared push data
bank_o_fifo_ren  out  NUM_BANKS  per-bank pop
bank_i_fifo_prf  in  NUM_BANKS*PRF_WIDTH  per-bank head data, show-ahead
bank_i_fifo_full  in  NUM_BANKS  per-bank full
bank_i_fifo_empty  in  NUM_BANKS  per-bank empty

Behaviour:
- State: head pointer (oldest bank), tail pointer (next bank to allocate), count (0..NUM_BANKS), FSM IDLE/MARK/DRAIN, drain target index.
- Reset: all three zero, FSM IDLE. All outputs 0, except bank_o_fifo_reset, which is all ones.
- cp_o_ready = IDLE & count<NUM_BANKS & !msp_i_valid.
- Checkpoint accept, in one cycle, on bank[tail]:
  - tag_wen with valid=1, abandoned=0.
  - fgr_wen with bank_o_fgr=cp_i_fgr.
  - fifo_reset=0.
  - tail+1 (wraps modulo NUM_BANKS), count+1.
- alloc_o_ready = IDLE & !msp_i_valid & (count==0 | !full[tail-1]).
  - count==0: accept, no push.
  - Otherwise push alloc_i_prf into bank[tail-1], the youngest bank.
  - Same cycle as a checkpoint accept: push goes to the previous youngest bank; the new bank starts empty.
- Resolve (IDLE, rsv_i_valid, count>0, fgr[head]==rsv_i_fgr):
  - bank[head] gets tag valid=0 and fifo_reset=0.
  - head+1, count-1.
  - No PRFs are returned.
  - A non-matching resolve is ignored.
  - Resolve and checkpoint in the same cycle update count by net 0.
- Mispredict: has priority; same-cycle cp/alloc/rsv are dropped.
  - Search the live banks for fgr==msp_i_fgr, giving index m.
  - Not found: ignored.
  - Found: assert tag_wen with valid=1, abandoned=1 on m and every younger live bank; set the drain target to m; go to MARK.
- MARK: one cycle; busy_o=1; go to DRAIN.
- DRAIN: busy_o=1; let y = tail-1.
  - !empty[y]: ren[y]=1, free_o_valid=1, free_o_prf=bank_i_fifo_prf[y]. One PRF per cycle.
  - empty[y]: bank[y] gets tag valid=0, abandoned=0 and fifo_reset=0; tail-1, count-1. If y==m, return to IDLE the next cycle.
- Drain order is youngest bank first; within a bank, FIFO order.
- Drain latency is (total PRFs in abandoned banks) + (number of abandoned banks) + 1 cycles.
- A mispredict arriving during MARK/DRAIN is ignored.
- Reset mid-drain returns to the reset state immediately; undrained PRFs are lost, and the free list is reset in the same event.

Optional Feature:
- Macro: ISSUE_RAT_FREELIST_CHECKPOINT_CTRL_ERRCHK_EN.
- Defined: err_o is a sticky error flag, cleared only by reset. It sets on:
  - resolve FGR not matching head;
  - resolve or mispredict with count==0;
  - mispredict FGR not found;
  - two live banks holding the same FGR at checkpoint accept.
- Undefined: err_o tied to 0 and no checking logic is synthesized.

Decomposition:
- Shared issue package: PRF_WIDTH, FGR_WIDTH and NUM_BANKS defaults; FSM state encodings IDLE=2'd0, MARK=2'd1, DRAIN=2'd2.
- One natural sub-module: issue_rat_freelist_checkpoint_match, a combinational FGR CAM over the live banks. It returns the hit and index, plus an age mask of banks from index to tail-1.

Test Plan:
- Reset, then cp fgr=3 -> bank0: valid=1, fgr=3, fifo_reset pulse; count=1; cp_o_ready stays 1.
- After cp, alloc PRFs 10,11,12,13, then a 5th alloc -> four pushes to bank0; 5th cycle alloc_o_ready=0 (full).
- cp fgr=1,2,3,4 accepted, 5th cp -> cp_o_ready=0; rsv fgr=1 -> bank0 cleared, head=1; cp again accepted into bank0.
- cp 1 (PRFs 5,6), cp 2 (PRF 7), msp fgr=1 -> busy 1; free_o sequence 7,5,6 over the drain; both banks invalid; IDLE after 7 cycles.
- msp and alloc in the same cycle -> alloc dropped; rsv with fgr not at head -> no state change; with the macro defined, err_o=1.
- Assert reset low during DRAIN -> all outputs return to reset values asynchronously; count=0 after release.
